// File: rtl/dtree_feature_loader_if.sv
// Streaming bus of the decision-tree feature loader: an inbound feature-byte
// stream and an outbound class-result stream, each with its own valid/ready pair.
interface dtree_feature_loader_if #(
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 2
);
  // Inbound feature stream
  logic               in_valid;
  logic               in_ready;
  logic [FEAT_W-1:0]  in_data;
  logic               in_sof;

  // Outbound class stream
  logic [CLASS_W-1:0] class_out;
  logic               class_valid;
  logic               class_ready;

  // Upstream feeder and downstream consumer side
  modport master (
    output in_valid, in_data, in_sof, class_ready,
    input  in_ready, class_out, class_valid
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, in_sof, class_ready,
    output in_ready, class_out, class_valid
  );
endinterface

// File: rtl/dtree_feature_loader.sv
// Feature loader for the combinational decision-tree classifier.
// Assembles NUM_FEAT feature bytes into a shadow buffer, publishes a complete
// sample on held registers X0..X6, captures the tree's class one edge later
// and offers it downstream. The shadow fills while a result waits, so only the
// final byte of the next sample can be held off.
// The X0..X6 port list assumes NUM_FEAT == 7.
module dtree_feature_loader #(
  parameter int NUM_FEAT = 7,
  parameter int FEAT_W   = 8,
  parameter int CLASS_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  dtree_feature_loader_if.slave bus,
  input  logic [CLASS_W-1:0]  i_class_in,
  output logic [FEAT_W-1:0]   o_x0,
  output logic [FEAT_W-1:0]   o_x1,
  output logic [FEAT_W-1:0]   o_x2,
  output logic [FEAT_W-1:0]   o_x3,
  output logic [FEAT_W-1:0]   o_x4,
  output logic [FEAT_W-1:0]   o_x5,
  output logic [FEAT_W-1:0]   o_x6,
  output logic                o_feat_valid,
  output logic [CNT_W-1:0]    o_sample_cnt,
  output logic [7:0]          o_drop_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  // Saturating increment for the drop counter: sticks at all-ones.
  function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Wrapping increment for the sample counter.
  function automatic logic [CNT_W-1:0] f_wrap_inc(input logic [CNT_W-1:0] v);
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Fill state
  logic [IDX_W-1:0]   r_idx;
  logic [FEAT_W-1:0]  r_shadow [NUM_FEAT-1];

  // Published sample
  logic [FEAT_W-1:0]  r_x [NUM_FEAT];
  logic               r_feat_valid;

  // Result stage
  logic               r_eval_pend;
  logic [CLASS_W-1:0] r_class_out;
  logic               r_class_valid;

  // Statistics
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [7:0]         r_drop_cnt;

  // Decode of the current handshake
  logic w_out_stall;
  logic w_in_ready;
  logic w_accept;
  logic w_at_first;
  logic w_at_last;
  logic w_restart;
  logic w_drop;
  logic w_complete;
  logic w_store;
  logic w_consume;

  // The last byte is held off only while the result stage is still busy with
  // the previous sample, so completing never overwrites an unread result.
  assign w_out_stall = r_class_valid && !bus.class_ready;
  assign w_at_first  = (r_idx == '0);
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_in_ready  = !(w_at_last && (r_eval_pend || w_out_stall));
  assign w_accept    = bus.in_valid && w_in_ready;

  // A start-of-frame byte always restarts the sample at slot 0. It counts as a
  // drop only when it abandons a partial sample; a headless byte at slot 0 is
  // discarded and counted.
  assign w_restart  = w_accept && bus.in_sof;
  assign w_drop     = w_accept && (w_at_first ? !bus.in_sof : bus.in_sof);
  assign w_complete = w_accept && !bus.in_sof && w_at_last && !w_at_first;
  assign w_store    = w_accept && !bus.in_sof && !w_at_first && !w_at_last;
  assign w_consume  = r_class_valid && bus.class_ready;

  // ---- Stage 0: byte capture into the shadow buffer ----

  // Slot pointer: restart on sof, wrap on completion, advance on a stored byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_restart) begin
      r_idx <= ONE_IDX;
    end else if (w_complete) begin
      r_idx <= '0;
    end else if (w_store) begin
      r_idx <= r_idx + ONE_IDX;
    end
  end

  // Shadow slots hold data only, so they need no reset; a partial sample is
  // made invisible by clearing the slot pointer instead.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_shadow[0] <= bus.in_data;
    end else if (w_store) begin
      r_shadow[r_idx] <= bus.in_data;
    end
  end

  // ---- Stage 1: publish the completed sample to the tree ----

  // X registers move only when a sample completes; the final byte bypasses
  // the shadow and lands directly in the last feature.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        r_x[i] <= '0;
      end
    end else if (w_complete) begin
      for (int i = 0; i < NUM_FEAT - 1; i++) begin
        r_x[i] <= r_shadow[i];
      end
      r_x[NUM_FEAT-1] <= bus.in_data;
    end
  end

  // Once a sample has been published the X registers always hold a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat_valid <= 1'b0;
    end else if (w_complete) begin
      r_feat_valid <= 1'b1;
    end
  end

  // ---- Stage 2: capture the tree's result and hand it downstream ----

  // Evaluation is requested by a completion and serviced on the next edge,
  // after the tree has seen the new X values for a full cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eval_pend <= 1'b0;
    end else if (w_complete) begin
      r_eval_pend <= 1'b1;
    end else if (r_eval_pend) begin
      r_eval_pend <= 1'b0;
    end
  end

  // A completion can only happen when the old result is absent or being
  // consumed on the same edge, so the eval cycle never finds a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_class_out   <= '0;
      r_class_valid <= 1'b0;
    end else if (r_eval_pend) begin
      r_class_out   <= i_class_in;
      r_class_valid <= 1'b1;
    end else if (w_consume) begin
      r_class_valid <= 1'b0;
    end
  end

  // Statistics counters: completed samples wrap, discards saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_complete) begin
        r_sample_cnt <= f_wrap_inc(r_sample_cnt);
      end
      if (w_drop) begin
        r_drop_cnt <= f_sat_inc8(r_drop_cnt);
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.class_out   = r_class_out;
  assign bus.class_valid = r_class_valid;

  assign o_x0         = r_x[0];
  assign o_x1         = r_x[1];
  assign o_x2         = r_x[2];
  assign o_x3         = r_x[3];
  assign o_x4         = r_x[4];
  assign o_x5         = r_x[5];
  assign o_x6         = r_x[6];
  assign o_feat_valid = r_feat_valid;
  assign o_sample_cnt = r_sample_cnt;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Self-checking bench for dtree_feature_loader: directed scenarios plus a
// randomized stream compared against a sample-level reference model.
module tb_dtree_feature_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtree_feature_loader_if #(.FEAT_W(8), .CLASS_W(2)) bus ();
  dtree_feature_loader_if #(.FEAT_W(8), .CLASS_W(2)) bus2 ();

  bit tie2;
  bit rnd_ready;
  logic rdy_fix;
  logic rdy_rand;
  logic [1:0] w_tree;
  logic [1:0] class_in;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6;
  logic [7:0] y0, y1, y2, y3, y4, y5, y6;
  logic [7:0] wx [7];
  logic [7:0] wy [7];
  logic fv, fv2;
  logic [15:0] scnt;
  logic [2:0] scnt2;
  logic [7:0] dcnt, dcnt2;

  // Stand-in for the tree: a fixed function of three features, or tied to 2.
  assign w_tree   = x0[1:0] ^ x3[1:0] ^ x6[1:0];
  assign class_in = tie2 ? 2'd2 : w_tree;
  assign bus.class_ready = rnd_ready ? rdy_rand : rdy_fix;

  // Second instance with a narrow sample counter follows the same stream.
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.in_data     = bus.in_data;
  assign bus2.in_sof      = bus.in_sof;
  assign bus2.class_ready = bus.class_ready;

  assign wx = '{x0, x1, x2, x3, x4, x5, x6};
  assign wy = '{y0, y1, y2, y3, y4, y5, y6};

  dtree_feature_loader #(.NUM_FEAT(7), .FEAT_W(8), .CLASS_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .i_class_in(class_in),
    .o_x0(x0), .o_x1(x1), .o_x2(x2), .o_x3(x3), .o_x4(x4), .o_x5(x5), .o_x6(x6),
    .o_feat_valid(fv), .o_sample_cnt(scnt), .o_drop_cnt(dcnt)
  );

  dtree_feature_loader #(.NUM_FEAT(7), .FEAT_W(8), .CLASS_W(2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .i_class_in(class_in),
    .o_x0(y0), .o_x1(y1), .o_x2(y2), .o_x3(y3), .o_x4(y4), .o_x5(y5), .o_x6(y6),
    .o_feat_valid(fv2), .o_sample_cnt(scnt2), .o_drop_cnt(dcnt2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: partial sample as a queue, published sample, counters.
  logic [7:0] m_part [$];
  logic [7:0] m_x [7];
  int m_cnt;
  int m_drop;
  bit m_fv;
  logic [1:0] exp_q [$];
  logic [1:0] got_q [$];

  function automatic void m_reset();
    m_part.delete();
    for (int i = 0; i < 7; i++) m_x[i] = 8'd0;
    m_cnt = 0; m_drop = 0; m_fv = 1'b0;
    exp_q.delete(); got_q.delete();
  endfunction

  function automatic void m_accept(input logic [7:0] d, input logic sof);
    logic [7:0] c;
    if (sof) begin
      if (m_part.size() != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_part.delete();
      m_part.push_back(d);
    end else if (m_part.size() == 0) begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end else begin
      m_part.push_back(d);
      if (m_part.size() == 7) begin
        for (int i = 0; i < 7; i++) m_x[i] = m_part[i];
        m_part.delete();
        m_cnt++;
        m_fv = 1'b1;
        c = m_x[0] ^ m_x[3] ^ m_x[6];
        exp_q.push_back(tie2 ? 2'd2 : c[1:0]);
      end
    end
  endfunction

  // Records every result the downstream side takes on the coming edge.
  always @(posedge clk) begin
    #2;
    if (!rst && bus.class_valid && bus.class_ready) got_q.push_back(bus.class_out);
  end

  // Random downstream readiness, refreshed each cycle.
  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 2) != 0);
  end

  // Drive one byte and hold it until accepted (entered and left at posedge+1).
  task automatic send(input logic [7:0] d, input logic sof);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = sof;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout in_ready stuck at %0b, need 1", bus.in_ready);
      @(posedge clk); #1;
    end else begin
      @(posedge clk);
      m_accept(d, sof);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(2);
    m_reset();
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== 8'd0) begin n_err++; $display("FAIL reset_x%0d got=%0h exp=0", i, wx[i]); end
    end
    n_cmp++; if ({fv, bus.class_valid, bus.class_out} !== 4'd0) begin n_err++; $display("FAIL reset_ctrl got=%0h exp=0", {fv, bus.class_valid, bus.class_out}); end
    n_cmp++; if ({scnt, dcnt} !== 24'd0) begin n_err++; $display("FAIL reset_cnt got=%0h exp=0", {scnt, dcnt}); end
    n_cmp++; if ({scnt2, dcnt2, fv2} !== 12'd0) begin n_err++; $display("FAIL reset_dut2 got=%0h exp=0", {scnt2, dcnt2, fv2}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    cycles(1);
  endtask

  task automatic test_basic();
    tie2 = 1'b1; rdy_fix = 1'b1;
    for (int i = 0; i < 7; i++) send(8'((i + 1) * 10), i == 0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== 8'((i + 1) * 10)) begin n_err++; $display("FAIL basic_x%0d got=%0d exp=%0d", i, wx[i], (i + 1) * 10); end
    end
    n_cmp++; if (fv !== 1'b1 || bus.class_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency fv/cv got=%0b%0b exp=10", fv, bus.class_valid); end
    n_cmp++; if (scnt !== 16'd1) begin n_err++; $display("FAIL basic_sample_cnt got=%0d exp=1", scnt); end
    cycles(1);
    n_cmp++; if (bus.class_valid !== 1'b1 || bus.class_out !== 2'd2) begin n_err++; $display("FAIL basic_class cv=%0b out=%0d exp cv=1 out=2", bus.class_valid, bus.class_out); end
    cycles(1);
    n_cmp++; if (bus.class_valid !== 1'b0) begin n_err++; $display("FAIL basic_class_pulse got=%0b exp=0", bus.class_valid); end
    n_cmp++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_err++; $display("FAIL basic_results got=%0d exp=1", got_q.size()); end
    else begin n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL basic_result got=%0d exp=%0d", got_q[0], exp_q[0]); end end
    tie2 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [1:0] a_cls;
    do_reset();
    rdy_fix = 1'b0;
    for (int i = 0; i < 7; i++) send(8'($urandom), i == 0);
    for (int i = 0; i < 6; i++) send(8'($urandom), i == 0);
    a_cls = exp_q[0];
    n_cmp++; if (bus.class_valid !== 1'b1 || bus.class_out !== a_cls) begin n_err++; $display("FAIL bp_first_held cv=%0b out=%0d exp cv=1 out=%0d", bus.class_valid, bus.class_out, a_cls); end
    bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.in_sof = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall cycle %0d in_ready got=%0b exp=0", k, bus.in_ready); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL bp_x_hold%0d got=%0h exp=%0h", i, wx[i], m_x[i]); end
    end
    rdy_fix = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release in_ready got=%0b exp=1", bus.in_ready); end
    @(posedge clk);
    m_accept(bus.in_data, 1'b0);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.class_valid !== 1'b0) begin n_err++; $display("FAIL bp_first_consumed cv got=%0b exp=0", bus.class_valid); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL bp_x_new%0d got=%0h exp=%0h", i, wx[i], m_x[i]); end
    end
    cycles(1);
    n_cmp++; if (bus.class_valid !== 1'b1 || bus.class_out !== exp_q[1]) begin n_err++; $display("FAIL bp_second cv=%0b out=%0d exp cv=1 out=%0d", bus.class_valid, bus.class_out, exp_q[1]); end
    cycles(2);
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL bp_results count got=%0d exp=2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_result%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (scnt !== 16'd2) begin n_err++; $display("FAIL bp_sample_cnt got=%0d exp=2", scnt); end
  endtask

  task automatic test_resync();
    logic [7:0] s;
    do_reset();
    rdy_fix = 1'b1;
    s = 8'($urandom);
    send(8'($urandom), 1'b1);
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    send(s, 1'b1);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    n_cmp++; if (dcnt !== 8'd1) begin n_err++; $display("FAIL resync_drop got=%0d exp=1", dcnt); end
    n_cmp++; if (x0 !== s) begin n_err++; $display("FAIL resync_x0 got=%0h exp=%0h", x0, s); end
    for (int i = 1; i < 7; i++) begin
      n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL resync_x%0d got=%0h exp=%0h", i, wx[i], m_x[i]); end
    end
    n_cmp++; if (scnt !== 16'd1) begin n_err++; $display("FAIL resync_sample_cnt got=%0d exp=1", scnt); end
    cycles(2);
  endtask

  task automatic test_drop();
    do_reset();
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b0);
    n_cmp++; if (dcnt !== 8'd2) begin n_err++; $display("FAIL drop_cnt got=%0d exp=2", dcnt); end
    n_cmp++; if (x0 !== 8'd0 || fv !== 1'b0 || scnt !== 16'd0) begin n_err++; $display("FAIL drop_no_update x0=%0h fv=%0b cnt=%0d exp 0", x0, fv, scnt); end
    for (int i = 0; i < 7; i++) send(8'($urandom), i == 0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL drop_then_x%0d got=%0h exp=%0h", i, wx[i], m_x[i]); end
    end
    cycles(2);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) send(8'($urandom), i == 0);
    send(8'h11, 1'b0);
    for (int i = 0; i < 4; i++) send(8'($urandom), i == 0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    m_reset();
    n_cmp++; if ({x0, x1, x2, x3, x4, x5, x6} !== 56'd0) begin n_err++; $display("FAIL midrst_x got=%0h exp=0", {x0, x1, x2, x3, x4, x5, x6}); end
    n_cmp++; if ({fv, bus.class_valid, bus.class_out, scnt, dcnt} !== 28'd0) begin n_err++; $display("FAIL midrst_ctrl got=%0h exp=0", {fv, bus.class_valid, bus.class_out, scnt, dcnt}); end
    for (int i = 0; i < 7; i++) send(8'($urandom), i == 0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL midrst_x%0d got=%0h exp=%0h", i, wx[i], m_x[i]); end
    end
    n_cmp++; if (scnt !== 16'd1 || dcnt !== 8'd0) begin n_err++; $display("FAIL midrst_cnt got=%0d/%0d exp=1/0", scnt, dcnt); end
    cycles(2);
  endtask

  task automatic test_random();
    logic sof;
    do_reset();
    rnd_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      for (int j = 0; j < 7; j++) begin
        sof = (j == 0);
        if ($urandom_range(0, 19) == 0) sof = ~sof;
        if ($urandom_range(0, 3) == 0) cycles(1);
        send(8'($urandom), sof);
        n_cmp++; if (scnt !== 16'(m_cnt) || dcnt !== 8'(m_drop) || fv !== m_fv) begin
          n_err++; $display("FAIL rnd_cnt s%0d cnt=%0d drop=%0d fv=%0b exp %0d %0d %0b", s, scnt, dcnt, fv, m_cnt, m_drop, m_fv);
        end
        for (int i = 0; i < 7; i++) begin
          n_cmp++; if (wx[i] !== m_x[i]) begin n_err++; $display("FAIL rnd_x%0d s%0d got=%0h exp=%0h", i, s, wx[i], m_x[i]); end
        end
      end
    end
    rnd_ready = 1'b0;
    rdy_fix = 1'b1;
    cycles(4);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_results count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_result%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (scnt2 !== 3'(m_cnt)) begin n_err++; $display("FAIL rnd_narrow_cnt got=%0d exp=%0d", scnt2, m_cnt % 8); end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    rdy_fix = 1'b1;
    for (int s = 0; s < 7; s++) for (int j = 0; j < 7; j++) send(8'($urandom), j == 0);
    n_cmp++; if (scnt2 !== 3'd7) begin n_err++; $display("FAIL wrap_top got=%0d exp=7", scnt2); end
    for (int j = 0; j < 7; j++) send(8'($urandom), j == 0);
    n_cmp++; if (scnt2 !== 3'd0) begin n_err++; $display("FAIL wrap_zero got=%0d exp=0", scnt2); end
    n_cmp++; if (scnt !== 16'd8) begin n_err++; $display("FAIL wrap_wide got=%0d exp=8", scnt); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (wy[i] !== m_x[i]) begin n_err++; $display("FAIL wrap_dut2_x%0d got=%0h exp=%0h", i, wy[i], m_x[i]); end
    end
    for (int k = 0; k < 300; k++) send(8'($urandom), 1'b0);
    n_cmp++; if (dcnt !== 8'd255 || m_drop != 255) begin n_err++; $display("FAIL sat_drop got=%0d exp=255", dcnt); end
    n_cmp++; if (dcnt2 !== 8'd255 || fv2 !== 1'b1) begin n_err++; $display("FAIL sat_dut2 drop=%0d fv=%0b exp 255 1", dcnt2, fv2); end
    n_cmp++; if (bus2.in_ready !== bus.in_ready || bus2.class_valid !== bus.class_valid || bus2.class_out !== bus.class_out) begin
      n_err++; $display("FAIL dut2_bus got=%0b%0b%0h exp=%0b%0b%0h", bus2.in_ready, bus2.class_valid, bus2.class_out, bus.in_ready, bus.class_valid, bus.class_out);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_sof = 1'b0;
    rdy_fix = 1'b1; tie2 = 1'b0; rnd_ready = 1'b0;
    m_reset();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_drop();
    test_mid_reset();
    test_random();
    test_wrap_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
